// File: rtl/msb_pkg.sv
// Shared widths and record types for the multi-stream buffer read port.
// Width helpers take the module parameters so every configuration derives its own sizes.
package msb_pkg;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ch_w(input int channels);
    return clog2_min1(channels);
  endfunction

  function automatic int st_w(input int nstrms, input int channels);
    return clog2_min1(nstrms / channels);
  endfunction

  function automatic int cl_w(input int ncl);
    return clog2_min1(ncl);
  endfunction

  function automatic int of_w(input int ways, input int beats);
    return clog2_min1(ways / beats);
  endfunction

  function automatic int line_w(input int data_width, input int ways);
    return data_width * ways;
  endfunction

  function automatic int cnt_w(input int credits);
    return $clog2(credits + 1);
  endfunction

  // Default build: 64-bit elements, 8-way lines, 2-element beats, 4 channels, 64 streams, 16 lines.
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_BEATS      = 2;
  localparam int DEF_CH_W       = ch_w(4);
  localparam int DEF_ST_W       = st_w(64, 4);
  localparam int DEF_CL_W       = cl_w(16);
  localparam int DEF_OF_W       = of_w(8, DEF_BEATS);

  typedef struct packed {
    logic [DEF_CH_W-1:0] ch;
    logic [DEF_ST_W-1:0] st;
    logic [DEF_CL_W-1:0] cl;
    logic [DEF_OF_W-1:0] of;
  } read_req_t;

  typedef struct packed {
    logic [DEF_CH_W-1:0]                 ch;
    logic [DEF_BEATS*DEF_DATA_WIDTH-1:0] data;
  } rd_beat_t;

endpackage

// File: rtl/msb_credit_fifo.sv
// Credit counter plus first-word-fall-through FIFO; data visible the cycle after push.
// Upstream ready is the registered credit count, so it never depends combinationally on out_rdy.
module msb_credit_fifo
  import msb_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int CNT_W = cnt_w(DEPTH),
  localparam int PW    = clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);

  logic [CNT_W-1:0] credit;
  logic [CNT_W-1:0] fill;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             acc;
  logic             pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign req_rdy = (credit != '0);
  assign acc     = req_vld & req_rdy;
  assign out_vld = (fill != '0);
  assign pop     = out_vld & out_rdy;
  // Empty FIFO drives zeros rather than stale entries.
  assign out_dat = out_vld ? mem[rptr] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit <= CNT_W'(DEPTH);
      fill   <= '0;
      wptr   <= '0;
      rptr   <= '0;
    end else begin
      if (acc && !pop)
        credit <= credit - CNT_W'(1);
      else if (pop && !acc)
        credit <= credit + CNT_W'(1);
      if (push_vld && !pop)
        fill <= fill + CNT_W'(1);
      else if (pop && !push_vld)
        fill <= fill - CNT_W'(1);
      if (push_vld)
        wptr <= nxt(wptr);
      if (pop)
        rptr <= nxt(rptr);
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld)
      mem[wptr] <= push_dat;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push_vld && fill == CNT_W'(DEPTH)));

endmodule

// File: rtl/msb_read_port.sv
// Multi-stream buffer read port: per-channel masked line writes, BEATS-element reads.
// Accept-to-valid is 2 cycles; credits bound in-flight reads so output backpressure never overflows.
module msb_read_port
  import msb_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  parameter  int WAYS       = 8,
  parameter  int BEATS      = 2,
  parameter  int CHANNELS   = 4,
  parameter  int NSTRMS     = 64,
  parameter  int NCL        = 16,
  parameter  int CREDITS    = 4,
  localparam int CH_W       = ch_w(CHANNELS),
  localparam int ST_W       = st_w(NSTRMS, CHANNELS),
  localparam int CL_W       = cl_w(NCL),
  localparam int OF_W       = of_w(WAYS, BEATS),
  localparam int LINE_W     = line_w(DATA_WIDTH, WAYS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_v,
  output logic                             i_r,
  input  logic [CH_W-1:0]                  i_ra_ch,
  input  logic [ST_W-1:0]                  i_ra_st,
  input  logic [CL_W-1:0]                  i_ra_cl,
  input  logic [OF_W-1:0]                  i_ra_of,
  output logic                             o_v,
  input  logic                             o_r,
  output logic [BEATS*DATA_WIDTH-1:0]      o_rd,
  output logic [CH_W-1:0]                  o_ch,
  input  logic [CHANNELS-1:0]              i_we,
  input  logic [CHANNELS*(ST_W+CL_W)-1:0]  i_wa,
  input  logic [CHANNELS*WAYS-1:0]         i_wm,
  input  logic [CHANNELS*LINE_W-1:0]       i_wd
);

  localparam int LA_W   = ST_W + CL_W;
  localparam int LINES  = (NSTRMS / CHANNELS) * NCL;
  localparam int WW     = clog2_min1(WAYS);
  localparam int BEAT_W = BEATS * DATA_WIDTH;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [BEAT_W-1:0] dat;
  } beat_t;

  logic                  acc;
  logic [LA_W-1:0]       rd_line;
  logic [OF_W-1:0]       of_eff;
  logic [WW-1:0]         widx;
  logic [BEAT_W-1:0]     sel_dat;
  logic [DATA_WIDTH-1:0] elem_q [CHANNELS][WAYS];
  logic                  s1_vld;
  logic [CH_W-1:0]       s1_ch;
  logic [BEAT_W-1:0]     s1_dat;
  beat_t                 push_dat;
  beat_t                 out_dat;

  assign acc     = i_v & i_r;
  assign rd_line = {i_ra_st, i_ra_cl};
  assign of_eff  = (WAYS == BEATS) ? '0 : i_ra_of;

  // One single-write-port bank per element so a masked line write touches only its own elements.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [LA_W-1:0] wa;
    assign wa = i_wa[c*LA_W +: LA_W];

    for (genvar j = 0; j < WAYS; j++) begin : g_way
      logic [DATA_WIDTH-1:0] mem [LINES];
      logic                  wr_en;
      logic [DATA_WIDTH-1:0] wd;

      assign wr_en = i_we[c] & i_wm[c*WAYS + j];
      assign wd    = i_wd[(c*WAYS + j)*DATA_WIDTH +: DATA_WIDTH];

      always_ff @(posedge clk) begin
        if (wr_en)
          mem[wa] <= wd;
      end

      // Write-first: a same-edge write to the line being read wins for its masked-in elements.
      assign elem_q[c][j] = (wr_en && wa == rd_line) ? wd : mem[rd_line];
    end
  end

  always_comb begin
    sel_dat = '0;
    widx    = '0;
    for (int k = 0; k < BEATS; k++) begin
      widx = WW'(int'(of_eff) * BEATS + k);
      sel_dat[k*DATA_WIDTH +: DATA_WIDTH] = elem_q[i_ra_ch][widx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld <= 1'b0;
      s1_ch  <= '0;
      s1_dat <= '0;
    end else begin
      s1_vld <= acc;
      if (acc) begin
        s1_ch  <= i_ra_ch;
        s1_dat <= sel_dat;
      end
    end
  end

  assign push_dat = {s1_ch, s1_dat};

  msb_credit_fifo #(
    .DEPTH (CREDITS),
    .WIDTH ($bits(beat_t))
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .req_vld  (i_v),
    .req_rdy  (i_r),
    .push_vld (s1_vld),
    .push_dat (push_dat),
    .out_vld  (o_v),
    .out_rdy  (o_r),
    .out_dat  (out_dat)
  );

  assign o_ch = out_dat.ch;
  assign o_rd = out_dat.dat;

endmodule

// File: tb/tb_msb_read_port.sv
// Scoreboard bench: default build plus a BEATS=WAYS=8, CHANNELS=2 build.
module tb_msb_read_port;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          i_v, i_r, o_v, o_r;
  logic [1:0]    i_ra_ch, i_ra_of, o_ch;
  logic [3:0]    i_ra_st, i_ra_cl, i_we;
  logic [127:0]  o_rd;
  logic [31:0]   i_wa, i_wm;
  logic [2047:0] i_wd;

  logic          v6, r6, ov6, or6, ch6, of6, och6;
  logic [4:0]    st6;
  logic [3:0]    cl6;
  logic [511:0]  rd6;
  logic [1:0]    we6;
  logic [17:0]   wa6;
  logic [15:0]   wm6;
  logic [1023:0] wd6;

  msb_read_port dut (
    .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r),
    .i_ra_ch(i_ra_ch), .i_ra_st(i_ra_st), .i_ra_cl(i_ra_cl), .i_ra_of(i_ra_of),
    .o_v(o_v), .o_r(o_r), .o_rd(o_rd), .o_ch(o_ch),
    .i_we(i_we), .i_wa(i_wa), .i_wm(i_wm), .i_wd(i_wd)
  );

  msb_read_port #(
    .DATA_WIDTH(64), .WAYS(8), .BEATS(8), .CHANNELS(2), .NSTRMS(64), .NCL(16), .CREDITS(4)
  ) dut6 (
    .clk(clk), .reset(reset), .i_v(v6), .i_r(r6),
    .i_ra_ch(ch6), .i_ra_st(st6), .i_ra_cl(cl6), .i_ra_of(of6),
    .o_v(ov6), .o_r(or6), .o_rd(rd6), .o_ch(och6),
    .i_we(we6), .i_wa(wa6), .i_wm(wm6), .i_wd(wd6)
  );

  typedef struct packed { logic [1:0] ch; logic [127:0] d; } exp_t;
  typedef struct packed { logic ch; logic [511:0] d; } exp6_t;

  int    n_cmp = 0, n_bad = 0, n_acc = 0, n_acc6 = 0;
  exp_t  q[$];
  exp6_t q6[$];
  exp_t  me;
  exp6_t me6;
  logic [63:0] mdl [4][256][8];

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && o_v && o_r) begin
      if (q.size() == 0) chk("unexpected_beat", o_v, 1'b0);
      else begin
        me = q.pop_front();
        chk("beat_data", o_rd, me.d);
        chk("beat_ch", o_ch, me.ch);
      end
    end
    if (reset === 1'b1 && ov6 && or6) begin
      if (q6.size() == 0) chk("unexpected_beat6", ov6, 1'b0);
      else begin
        me6 = q6.pop_front();
        chk("beat6_data", rd6, me6.d);
        chk("beat6_ch", och6, me6.ch);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input int c, input int st, input int cl, input logic [7:0] m, input logic [511:0] ln);
    i_we[c]          = 1'b1;
    i_wa[c*8 +: 8]   = {st[3:0], cl[3:0]};
    i_wm[c*8 +: 8]   = m;
    i_wd[c*512 +: 512] = ln;
  endtask

  task automatic rd(input int c, input int st, input int cl, input int of);
    i_v = 1'b1; i_ra_ch = c[1:0]; i_ra_st = st[3:0]; i_ra_cl = cl[3:0]; i_ra_of = of[1:0];
  endtask

  // Model applies writes before the same-edge read, giving write-first expectations.
  task automatic step();
    logic [7:0] la;
    @(negedge clk);
    for (int c = 0; c < 4; c++)
      if (i_we[c])
        for (int j = 0; j < 8; j++)
          if (i_wm[c*8 + j]) mdl[c][i_wa[c*8 +: 8]][j] = i_wd[(c*8 + j)*64 +: 64];
    if (i_v && i_r) begin
      la = {i_ra_st, i_ra_cl};
      q.push_back('{ch: i_ra_ch, d: {mdl[i_ra_ch][la][2*i_ra_of + 1], mdl[i_ra_ch][la][2*i_ra_of]}});
      n_acc++;
    end
    @(posedge clk); #1;
    i_we = '0; i_wm = '0; i_v = 1'b0;
  endtask

  task automatic rd6_step(input int c, input int st, input int cl, input int of, input logic [511:0] e);
    v6 = 1'b1; ch6 = c[0]; st6 = st[4:0]; cl6 = cl[3:0]; of6 = of[0];
    @(negedge clk);
    if (r6) begin q6.push_back('{ch: c[0], d: e}); n_acc6++; end
    @(posedge clk); #1;
    v6 = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((q.size() != 0 || q6.size() != 0) && n < 64) begin @(posedge clk); #1; n++; end
    chk(tag, q.size() + q6.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [511:0] ln, la6, lb6;
    int a0;
    reset = 1'b1; o_r = 1'b0; or6 = 1'b1;
    i_v = 0; i_ra_ch = 0; i_ra_st = 0; i_ra_cl = 0; i_ra_of = 0;
    i_we = '0; i_wa = '0; i_wm = '0; i_wd = '0;
    v6 = 0; ch6 = 0; st6 = 0; cl6 = 0; of6 = 0; we6 = '0; wa6 = '0; wm6 = '0; wd6 = '0;

    #2 reset = 1'b0;
    #1;
    chk("rst_o_v", o_v, 1'b0);
    chk("rst_i_r", i_r, 1'b1);
    chk("rst_o_rd", o_rd, '0);
    chk("rst_o_ch", o_ch, 2'd0);
    idle(2);
    reset = 1'b1;
    idle(1);

    // 1: basic write then read, latency 2
    o_r = 1'b1;
    for (int j = 0; j < 8; j++) ln[j*64 +: 64] = 64'h10 + 64'(j);
    wr(2, 5, 3, 8'hFF, ln); step();
    rd(2, 5, 3, 1); step();
    chk("t1_no_early_o_v", o_v, 1'b0);
    idle(1);
    chk("t1_o_v_lat2", o_v, 1'b1);
    chk("t1_o_rd", o_rd, {64'h13, 64'h12});
    chk("t1_o_ch", o_ch, 2'd2);
    wait_drain("t1_drain");

    // 2: backpressure stops after CREDITS accepts
    o_r = 1'b0;
    a0 = n_acc;
    for (int i = 0; i < 8; i++) begin rd(2, 5, 3, i % 4); step(); end
    chk("t2_accepts", n_acc - a0, 4);
    chk("t2_i_r_low", i_r, 1'b0);
    o_r = 1'b1;
    chk("t2_i_r_before_pop", i_r, 1'b0);
    idle(1);
    chk("t2_i_r_after_pop", i_r, 1'b1);
    wait_drain("t2_drain");

    // 3: masked write colliding with a read of the same line
    wr(1, 7, 9, 8'hFF, {8{64'hAAAAAAAAAAAAAAAA}}); step();
    wr(1, 7, 9, 8'b0000_0101, {8{64'h5555555555555555}});
    rd(1, 7, 9, 0); step();
    idle(1);
    chk("t3_write_first", o_rd, {64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555});
    wait_drain("t3_drain");

    // 4: all channels written together, back-to-back reads without bubbles
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 8; j++) ln[j*64 +: 64] = 64'hC000 + 64'(c*256 + j);
      wr(c, 3, c + 1, 8'hFF, ln);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      rd(i, 3, i + 1, i); step();
      if (i >= 1) chk("t4_no_bubble", o_v, 1'b1);
    end
    idle(1);
    chk("t4_last_beat", o_v, 1'b1);
    idle(1);
    chk("t4_empty_after", o_v, 1'b0);
    wait_drain("t4_drain");

    // 5: reset with reads in flight
    o_r = 1'b0;
    rd(0, 3, 1, 0); step();
    rd(1, 3, 2, 1); step();
    chk("t5_pre_o_v", o_v, 1'b1);
    reset = 1'b0;
    #1;
    chk("t5_rst_o_v", o_v, 1'b0);
    chk("t5_rst_i_r", i_r, 1'b1);
    chk("t5_rst_o_rd", o_rd, '0);
    q.delete();
    idle(2);
    reset = 1'b1;
    idle(1);
    a0 = n_acc;
    for (int i = 0; i < 6; i++) begin rd(i % 4, 3, (i % 4) + 1, i % 4); step(); end
    chk("t5_accepts", n_acc - a0, 4);
    chk("t5_i_r_low", i_r, 1'b0);
    o_r = 1'b1;
    wait_drain("t5_drain");

    // 6: whole-line beats, offset ignored
    for (int j = 0; j < 8; j++) begin
      la6[j*64 +: 64] = 64'h600 + 64'(j);
      lb6[j*64 +: 64] = 64'h700 + 64'(j);
    end
    we6 = 2'b11; wa6 = {5'd2, 4'd15, 5'd17, 4'd6}; wm6 = 16'hFFFF; wd6 = {lb6, la6};
    idle(1);
    we6 = '0; wm6 = '0;
    rd6_step(1, 2, 15, 1, lb6);
    rd6_step(0, 17, 6, 0, la6);
    chk("t6_accepts", n_acc6, 2);
    wait_drain("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
